// File: rtl/ahb_master_protocol_checker_pkg.sv
// ============================================================================
// AhbGlobalPackage : shared AHB encodings, checker error-bit map, burst helpers
// Revision: 1.0
// ============================================================================
`default_nettype none

package AhbGlobalPackage;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [0:0] {
        IDLE_ST  = 1'b0,
        IN_BURST = 1'b1
    } burst_state_e;

    localparam int ERR_W = 9;

    localparam int c_err_ctrl_unstable     = 0;
    localparam int c_err_seq_outside_burst = 1;
    localparam int c_err_addr_seq_mismatch = 2;
    localparam int c_err_burst_overrun     = 3;
    localparam int c_err_burst_early_term  = 4;
    localparam int c_err_size_illegal      = 5;
    localparam int c_err_addr_unaligned    = 6;
    localparam int c_err_wstrb_illegal     = 7;
    localparam int c_err_kb_cross          = 8;

    // INCR has no defined length and reports 0 beats
    function automatic logic [4:0] burst_beats(input logic [2:0] burst);
        case (burst)
            HBURST_SINGLE:               burst_beats = 5'd1;
            HBURST_WRAP4, HBURST_INCR4:  burst_beats = 5'd4;
            HBURST_WRAP8, HBURST_INCR8:  burst_beats = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: burst_beats = 5'd16;
            default:                     burst_beats = 5'd0;
        endcase
    endfunction

    function automatic logic burst_is_wrap(input logic [2:0] burst);
        return (burst == HBURST_WRAP4) || (burst == HBURST_WRAP8) || (burst == HBURST_WRAP16);
    endfunction

    function automatic logic burst_is_fixed(input logic [2:0] burst);
        return (burst != HBURST_SINGLE) && (burst != HBURST_INCR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_master_protocol_checker_addr_calc.sv
// ============================================================================
// ahb_burst_addr_calc : next-beat address, wrap boundary and 1KB crossing
// Revision: 1.0
// ============================================================================
`default_nettype none

module ahb_burst_addr_calc
    import AhbGlobalPackage::*;
#(
    parameter int ADDR_WIDTH = 32
)(
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    input  logic [2:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic                  kb_cross
);

    logic [ADDR_WIDTH-1:0] w_incr;
    logic [ADDR_WIDTH-1:0] w_linear;
    logic [ADDR_WIDTH-1:0] w_wrap_mask;
    logic [ADDR_WIDTH-1:0] w_wrap_base;
    logic                  w_is_wrap;

    assign w_incr      = ADDR_WIDTH'(1) << size;
    assign w_linear    = addr + w_incr;
    assign w_is_wrap   = burst_is_wrap(burst);
    assign w_wrap_mask = (ADDR_WIDTH'(burst_beats(burst)) << size) - ADDR_WIDTH'(1);
    assign w_wrap_base = addr & ~w_wrap_mask;

    // Wrapping bursts keep the block base and roll the offset within the block
    assign next_addr = w_is_wrap ? (w_wrap_base | (w_linear & w_wrap_mask)) : w_linear;
    assign kb_cross  = !w_is_wrap && (next_addr[ADDR_WIDTH-1:10] != addr[ADDR_WIDTH-1:10]);

endmodule

`default_nettype wire

// File: rtl/ahb_master_protocol_checker.sv
// ============================================================================
// ahb_master_protocol_checker : passive monitor of AHB master address/control
// Revision: 1.0
// ============================================================================
`default_nettype none

module ahb_master_protocol_checker
    import AhbGlobalPackage::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int ERR_CNT_WIDTH = 16
)(
    input  logic                     hclk,
    input  logic                     hresetn,
    input  logic [ADDR_WIDTH-1:0]    haddr,
    input  logic [1:0]               htrans,
    input  logic                     hwrite,
    input  logic [2:0]               hsize,
    input  logic [2:0]               hburst,
    input  logic [3:0]               hprot,
    input  logic [DATA_WIDTH/8-1:0]  hwstrb,
    input  logic                     hready,
    input  logic                     hresp,
    input  logic                     clrErr,
    output logic [ERR_W-1:0]         errFlags,
    output logic [ERR_W-1:0]         errPulse,
    output logic [ERR_CNT_WIDTH-1:0] errCount,
    output logic                     inBurst
);

    localparam int STRB_W    = DATA_WIDTH / 8;
    localparam int LANE_BITS = $clog2(STRB_W);
    localparam logic [2:0] c_max_size = 3'(LANE_BITS);

    function automatic logic [STRB_W-1:0] lane_mask(input logic [LANE_BITS-1:0] off,
                                                    input logic [2:0] size);
        logic [STRB_W-1:0] m;
        int lo;
        int n;
        lo = int'(off);
        n  = 1 << size;
        m  = '0;
        for (int i = 0; i < STRB_W; i++) m[i] = (i >= lo) && (i < lo + n);
        return m;
    endfunction

    burst_state_e          r_state, w_state_nxt;
    logic [4:0]            r_beats_left, w_beats_nxt;
    logic [2:0]            r_cap_size, r_cap_burst;
    logic                  r_cap_write, r_err_seen, r_last_fixed_done;
    logic [ADDR_WIDTH-1:0] r_last_addr;
    logic                  r_prev_ready, r_prev_write, r_prev_resp;
    logic [1:0]            r_prev_trans;
    logic [ADDR_WIDTH-1:0] r_prev_addr;
    logic [2:0]            r_prev_size, r_prev_burst;
    logic [3:0]            r_prev_prot;
    logic                  r_dp_valid;
    logic [LANE_BITS-1:0]  r_dp_off;
    logic [2:0]            r_dp_size;

    logic                  w_acc, w_seq_acc, w_nonseq_acc, w_open, w_fixed_done;
    logic                  w_seq_in_burst, w_kb_cross;
    logic [ADDR_WIDTH-1:0] w_exp_addr, w_align_mask;
    logic [ERR_W-1:0]      w_pulse;

    assign w_acc          = hready && htrans[1];
    assign w_seq_acc      = hready && (htrans == HTRANS_SEQ);
    assign w_nonseq_acc   = hready && (htrans == HTRANS_NONSEQ);
    assign w_open         = w_nonseq_acc && (hburst != HBURST_SINGLE);
    assign w_seq_in_burst = w_seq_acc && (r_state == IN_BURST);
    assign w_align_mask   = (ADDR_WIDTH'(1) << hsize) - ADDR_WIDTH'(1);
    assign inBurst        = (r_state == IN_BURST);

    ahb_burst_addr_calc #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_calc (
        .addr      (r_last_addr),
        .size      (r_cap_size),
        .burst     (r_cap_burst),
        .next_addr (w_exp_addr),
        .kb_cross  (w_kb_cross)
    );

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) r_state <= IDLE_ST;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_beats_nxt  = r_beats_left;
        w_fixed_done = 1'b0;
        case (r_state)
            IDLE_ST: begin
                if (w_open) begin
                    w_state_nxt = IN_BURST;
                    w_beats_nxt = burst_beats(hburst) - 5'd1;
                end
            end
            IN_BURST: begin
                if (w_seq_acc) begin
                    w_beats_nxt = r_beats_left - 5'd1;
                    if (burst_is_fixed(r_cap_burst) && (r_beats_left == 5'd1)) begin
                        w_state_nxt  = IDLE_ST;
                        w_fixed_done = 1'b1;
                    end
                end else if (w_nonseq_acc) begin
                    if (w_open) w_beats_nxt = burst_beats(hburst) - 5'd1;
                    else        w_state_nxt = IDLE_ST;
                end else if (hready && (htrans == HTRANS_IDLE)) begin
                    w_state_nxt = IDLE_ST;
                end
            end
            default: w_state_nxt = IDLE_ST;
        endcase
    end

    always_comb begin
        w_pulse = '0;
        // An ERROR response in the previous sample lets the master drop to IDLE
        w_pulse[c_err_ctrl_unstable] = !r_prev_ready && r_prev_trans[1] && !r_prev_resp &&
            ((htrans != r_prev_trans) || (haddr != r_prev_addr) || (hwrite != r_prev_write) ||
             (hsize != r_prev_size) || (hburst != r_prev_burst) || (hprot != r_prev_prot));
        w_pulse[c_err_seq_outside_burst] = (r_state == IDLE_ST) && hready &&
            ((htrans == HTRANS_BUSY) || ((htrans == HTRANS_SEQ) && !r_last_fixed_done));
        w_pulse[c_err_addr_seq_mismatch] = w_seq_in_burst &&
            ((haddr != w_exp_addr) || (hsize != r_cap_size) ||
             (hwrite != r_cap_write) || (hburst != r_cap_burst));
        w_pulse[c_err_burst_overrun] = (r_state == IDLE_ST) && w_seq_acc && r_last_fixed_done;
        w_pulse[c_err_burst_early_term] = (r_state == IN_BURST) && burst_is_fixed(r_cap_burst) &&
            (r_beats_left != 5'd0) && hready &&
            ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_IDLE)) && !(r_err_seen || hresp);
        w_pulse[c_err_size_illegal]   = htrans[1] && (hsize > c_max_size);
        w_pulse[c_err_addr_unaligned] = htrans[1] && |(haddr & w_align_mask);
        w_pulse[c_err_wstrb_illegal]  = hready && r_dp_valid &&
            |(hwstrb & ~lane_mask(r_dp_off, r_dp_size));
        w_pulse[c_err_kb_cross] = w_seq_in_burst && !burst_is_wrap(r_cap_burst) && w_kb_cross;
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_beats_left      <= '0;
            r_cap_size        <= '0;
            r_cap_burst       <= '0;
            r_cap_write       <= 1'b0;
            r_err_seen        <= 1'b0;
            r_last_fixed_done <= 1'b0;
            r_last_addr       <= '0;
            r_prev_ready      <= 1'b0;
            r_prev_trans      <= '0;
            r_prev_addr       <= '0;
            r_prev_write      <= 1'b0;
            r_prev_size       <= '0;
            r_prev_burst      <= '0;
            r_prev_prot       <= '0;
            r_prev_resp       <= 1'b0;
            r_dp_valid        <= 1'b0;
            r_dp_off          <= '0;
            r_dp_size         <= '0;
        end else begin
            r_beats_left <= w_beats_nxt;
            r_prev_ready <= hready;
            r_prev_trans <= htrans;
            r_prev_addr  <= haddr;
            r_prev_write <= hwrite;
            r_prev_size  <= hsize;
            r_prev_burst <= hburst;
            r_prev_prot  <= hprot;
            r_prev_resp  <= hresp;
            if (w_open) begin
                r_cap_size  <= hsize;
                r_cap_burst <= hburst;
                r_cap_write <= hwrite;
                r_err_seen  <= 1'b0;
            end else if (hresp) begin
                r_err_seen  <= 1'b1;
            end
            if (w_acc) r_last_addr <= haddr;
            if (w_fixed_done)                           r_last_fixed_done <= 1'b1;
            else if (w_acc || (htrans == HTRANS_IDLE))  r_last_fixed_done <= 1'b0;
            // Write data phase follows the address phase accepted on the same edge
            if (hready) begin
                r_dp_valid <= w_acc && hwrite;
                r_dp_off   <= haddr[LANE_BITS-1:0];
                r_dp_size  <= hsize;
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            errPulse <= '0;
            errFlags <= '0;
            errCount <= '0;
        end else begin
            errPulse <= w_pulse;
            if (clrErr) begin
                errFlags <= w_pulse;
                errCount <= ERR_CNT_WIDTH'(|w_pulse);
            end else begin
                errFlags <= errFlags | w_pulse;
                if ((|w_pulse) && (errCount != {ERR_CNT_WIDTH{1'b1}}))
                    errCount <= errCount + ERR_CNT_WIDTH'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ahb_master_protocol_checker.sv
// ============================================================================
// tb_ahb_master_protocol_checker : directed scoreboard bench for the checker
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ahb_master_protocol_checker;

    logic        hclk;
    logic        hresetn;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [3:0]  hwstrb;
    logic        hready;
    logic        hresp;
    logic        clrErr;
    logic [8:0]  errFlags;
    logic [8:0]  errPulse;
    logic [15:0] errCount;
    logic        inBurst;

    ahb_master_protocol_checker #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .ERR_CNT_WIDTH (16)
    ) dut (
        .hclk     (hclk),
        .hresetn  (hresetn),
        .haddr    (haddr),
        .htrans   (htrans),
        .hwrite   (hwrite),
        .hsize    (hsize),
        .hburst   (hburst),
        .hprot    (hprot),
        .hwstrb   (hwstrb),
        .hready   (hready),
        .hresp    (hresp),
        .clrErr   (clrErr),
        .errFlags (errFlags),
        .errPulse (errPulse),
        .errCount (errCount),
        .inBurst  (inBurst)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    typedef struct {
        bit          cp;
        logic [8:0]  p;
        bit          cf;
        logic [8:0]  f;
        bit          cc;
        logic [15:0] c;
        bit          cb;
        logic        b;
        int          id;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    exp_t m;
    int   total = 0;
    int   bad   = 0;
    int   step_id = 0;

    localparam logic [1:0] T_IDLE = 2'd0, T_NSEQ = 2'd2, T_SEQ = 2'd3;
    localparam logic [2:0] B_SINGLE = 3'd0, B_INCR = 3'd1, B_WRAP4 = 3'd2,
                           B_INCR4 = 3'd3, B_INCR8 = 3'd5;

    task automatic drv(input logic [1:0] t, input logic [31:0] a, input logic [2:0] bu,
                       input logic [2:0] sz, input logic w, input logic rdy,
                       input logic rsp, input logic [3:0] st);
        htrans = t; haddr = a; hburst = bu; hsize = sz;
        hwrite = w; hready = rdy; hresp = rsp; hwstrb = st;
    endtask

    task automatic idle();
        drv(T_IDLE, 32'h0, B_SINGLE, 3'd2, 1'b0, 1'b1, 1'b0, 4'h0);
    endtask

    task automatic eall(input logic [8:0] p, input logic [8:0] f,
                        input logic [15:0] c, input logic b);
        cur.cp = 1'b1; cur.p = p;
        cur.cf = 1'b1; cur.f = f;
        cur.cc = 1'b1; cur.c = c;
        cur.cb = 1'b1; cur.b = b;
    endtask

    task automatic ecnt(input logic [15:0] c);
        cur.cc = 1'b1; cur.c = c;
    endtask

    // Queue the expectation for the coming edge, then advance one cycle
    task automatic tick();
        cur.id = step_id;
        step_id++;
        q.push_back(cur);
        cur.cp = 1'b0; cur.cf = 1'b0; cur.cc = 1'b0; cur.cb = 1'b0;
        @(negedge hclk);
    endtask

    always @(posedge hclk) begin
        #1;
        if (q.size() != 0) begin
            m = q.pop_front();
            if (m.cp) begin
                total++;
                if (errPulse !== m.p) begin
                    bad++;
                    $display("FAIL pulse step=%0d got=%h want=%h", m.id, errPulse, m.p);
                end
            end
            if (m.cf) begin
                total++;
                if (errFlags !== m.f) begin
                    bad++;
                    $display("FAIL flags step=%0d got=%h want=%h", m.id, errFlags, m.f);
                end
            end
            if (m.cc) begin
                total++;
                if (errCount !== m.c) begin
                    bad++;
                    $display("FAIL count step=%0d got=%h want=%h", m.id, errCount, m.c);
                end
            end
            if (m.cb) begin
                total++;
                if (inBurst !== m.b) begin
                    bad++;
                    $display("FAIL inburst step=%0d got=%b want=%b", m.id, inBurst, m.b);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        cur.cp = 1'b0; cur.cf = 1'b0; cur.cc = 1'b0; cur.cb = 1'b0;
        cur.p = '0; cur.f = '0; cur.c = '0; cur.b = 1'b0; cur.id = 0;
        hresetn = 1'b0; clrErr = 1'b0; hprot = 4'h0;
        idle();
        @(negedge hclk);

        // Reset state
        eall(9'h000, 9'h000, 16'd0, 1'b0); tick();
        eall(9'h000, 9'h000, 16'd0, 1'b0); tick();
        hresetn = 1'b1;

        // WRAP4 word burst 0x38, 0x3C, 0x30, 0x34
        drv(T_NSEQ, 32'h38, B_WRAP4, 3'd2, 1'b0, 1'b1, 1'b0, 4'h0); eall(9'h000, 9'h000, 16'd0, 1'b1); tick();
        drv(T_SEQ,  32'h3C, B_WRAP4, 3'd2, 1'b0, 1'b1, 1'b0, 4'h0); eall(9'h000, 9'h000, 16'd0, 1'b1); tick();
        drv(T_SEQ,  32'h30, B_WRAP4, 3'd2, 1'b0, 1'b1, 1'b0, 4'h0); eall(9'h000, 9'h000, 16'd0, 1'b1); tick();
        drv(T_SEQ,  32'h34, B_WRAP4, 3'd2, 1'b0, 1'b1, 1'b0, 4'h0); eall(9'h000, 9'h000, 16'd0, 1'b0); tick();
        idle(); eall(9'h000, 9'h000, 16'd0, 1'b0); tick();

        // Address changes during a wait state
        drv(T_NSEQ, 32'h100, B_SINGLE, 3'd2, 1'b0, 1'b0, 1'b0, 4'h0); eall(9'h000, 9'h000, 16'd0, 1'b0); tick();
        drv(T_NSEQ, 32'h104, B_SINGLE, 3'd2, 1'b0, 1'b0, 1'b0, 4'h0); eall(9'h001, 9'h001, 16'd1, 1'b0); tick();
        drv(T_NSEQ, 32'h104, B_SINGLE, 3'd2, 1'b0, 1'b1, 1'b0, 4'h0); eall(9'h000, 9'h001, 16'd1, 1'b0); tick();
        idle(); clrErr = 1'b1; eall(9'h000, 9'h000, 16'd0, 1'b0); tick(); clrErr = 1'b0;

        // INCR burst crossing 1KB, then an out-of-sequence beat, then an unaligned single
        drv(T_NSEQ, 32'h3F8, B_INCR, 3'd2, 1'b0, 1'b1, 1'b0, 4'h0); eall(9'h000, 9'h000, 16'd0, 1'b1); tick();
        drv(T_SEQ,  32'h3FC, B_INCR, 3'd2, 1'b0, 1'b1, 1'b0, 4'h0); eall(9'h000, 9'h000, 16'd0, 1'b1); tick();
        drv(T_SEQ,  32'h400, B_INCR, 3'd2, 1'b0, 1'b1, 1'b0, 4'h0); eall(9'h100, 9'h100, 16'd1, 1'b1); tick();
        drv(T_SEQ,  32'h408, B_INCR, 3'd2, 1'b0, 1'b1, 1'b0, 4'h0); eall(9'h004, 9'h104, 16'd2, 1'b1); tick();
        idle(); eall(9'h000, 9'h104, 16'd2, 1'b0); tick();
        drv(T_NSEQ, 32'h1, B_SINGLE, 3'd2, 1'b0, 1'b1, 1'b0, 4'h0); eall(9'h040, 9'h144, 16'd3, 1'b0); tick();
        idle(); clrErr = 1'b1; eall(9'h000, 9'h000, 16'd0, 1'b0); tick(); clrErr = 1'b0;

        // INCR4 terminated early by a NONSEQ with OKAY responses
        drv(T_NSEQ, 32'h0,   B_INCR4,  3'd2, 1'b0, 1'b1, 1'b0, 4'h0); eall(9'h000, 9'h000, 16'd0, 1'b1); tick();
        drv(T_SEQ,  32'h4,   B_INCR4,  3'd2, 1'b0, 1'b1, 1'b0, 4'h0); eall(9'h000, 9'h000, 16'd0, 1'b1); tick();
        drv(T_NSEQ, 32'h200, B_SINGLE, 3'd2, 1'b0, 1'b1, 1'b0, 4'h0); eall(9'h010, 9'h010, 16'd1, 1'b0); tick();
        idle(); clrErr = 1'b1; eall(9'h000, 9'h000, 16'd0, 1'b0); tick(); clrErr = 1'b0;

        // Same termination after a two-cycle ERROR response is allowed
        drv(T_NSEQ, 32'h0,   B_INCR4,  3'd2, 1'b0, 1'b1, 1'b0, 4'h0); eall(9'h000, 9'h000, 16'd0, 1'b1); tick();
        drv(T_SEQ,  32'h4,   B_INCR4,  3'd2, 1'b0, 1'b1, 1'b0, 4'h0); eall(9'h000, 9'h000, 16'd0, 1'b1); tick();
        drv(T_SEQ,  32'h8,   B_INCR4,  3'd2, 1'b0, 1'b0, 1'b1, 4'h0); eall(9'h000, 9'h000, 16'd0, 1'b1); tick();
        drv(T_NSEQ, 32'h200, B_SINGLE, 3'd2, 1'b0, 1'b1, 1'b1, 4'h0); eall(9'h000, 9'h000, 16'd0, 1'b0); tick();
        idle(); eall(9'h000, 9'h000, 16'd0, 1'b0); tick();

        // INCR4 completed, followed directly by an extra SEQ
        drv(T_NSEQ, 32'h0,  B_INCR4, 3'd2, 1'b0, 1'b1, 1'b0, 4'h0); eall(9'h000, 9'h000, 16'd0, 1'b1); tick();
        drv(T_SEQ,  32'h4,  B_INCR4, 3'd2, 1'b0, 1'b1, 1'b0, 4'h0); eall(9'h000, 9'h000, 16'd0, 1'b1); tick();
        drv(T_SEQ,  32'h8,  B_INCR4, 3'd2, 1'b0, 1'b1, 1'b0, 4'h0); eall(9'h000, 9'h000, 16'd0, 1'b1); tick();
        drv(T_SEQ,  32'hC,  B_INCR4, 3'd2, 1'b0, 1'b1, 1'b0, 4'h0); eall(9'h000, 9'h000, 16'd0, 1'b0); tick();
        drv(T_SEQ,  32'h10, B_INCR4, 3'd2, 1'b0, 1'b1, 1'b0, 4'h0); eall(9'h008, 9'h008, 16'd1, 1'b0); tick();
        idle(); clrErr = 1'b1; eall(9'h000, 9'h000, 16'd0, 1'b0); tick(); clrErr = 1'b0;

        // Halfword write at 0x2: lanes 2..3 are legal, 0..1 are not
        drv(T_NSEQ, 32'h2, B_SINGLE, 3'd1, 1'b1, 1'b1, 1'b0, 4'h0); eall(9'h000, 9'h000, 16'd0, 1'b0); tick();
        drv(T_IDLE, 32'h0, B_SINGLE, 3'd2, 1'b0, 1'b1, 1'b0, 4'b0011); eall(9'h080, 9'h080, 16'd1, 1'b0); tick();
        idle(); clrErr = 1'b1; eall(9'h000, 9'h000, 16'd0, 1'b0); tick(); clrErr = 1'b0;
        drv(T_NSEQ, 32'h2, B_SINGLE, 3'd1, 1'b1, 1'b1, 1'b0, 4'h0); eall(9'h000, 9'h000, 16'd0, 1'b0); tick();
        drv(T_IDLE, 32'h0, B_SINGLE, 3'd2, 1'b0, 1'b1, 1'b0, 4'b1100); eall(9'h000, 9'h000, 16'd0, 1'b0); tick();
        idle(); eall(9'h000, 9'h000, 16'd0, 1'b0); tick();

        // Reset in the middle of an INCR8 burst, then SEQ straight out of reset
        drv(T_NSEQ, 32'h40, B_INCR8, 3'd2, 1'b0, 1'b1, 1'b0, 4'h0); eall(9'h000, 9'h000, 16'd0, 1'b1); tick();
        drv(T_SEQ,  32'h44, B_INCR8, 3'd2, 1'b0, 1'b1, 1'b0, 4'h0); eall(9'h000, 9'h000, 16'd0, 1'b1); tick();
        drv(T_SEQ,  32'h4C, B_INCR8, 3'd2, 1'b0, 1'b1, 1'b0, 4'h0); eall(9'h004, 9'h004, 16'd1, 1'b1); tick();
        idle(); hresetn = 1'b0; eall(9'h000, 9'h000, 16'd0, 1'b0); tick();
        hresetn = 1'b1;
        drv(T_SEQ, 32'h0, B_INCR, 3'd2, 1'b0, 1'b1, 1'b0, 4'h0); eall(9'h002, 9'h002, 16'd1, 1'b0); tick();
        idle(); clrErr = 1'b1; eall(9'h000, 9'h000, 16'd0, 1'b0); tick(); clrErr = 1'b0;

        // Counter saturation with a doubleword transfer on a 32-bit bus every cycle
        drv(T_NSEQ, 32'h0, B_SINGLE, 3'd3, 1'b0, 1'b1, 1'b0, 4'h0);
        for (int k = 1; k <= 65540; k++) begin
            if (k == 1)          eall(9'h020, 9'h020, 16'd1, 1'b0);
            else if (k == 65534) ecnt(16'hFFFE);
            else if (k == 65535) ecnt(16'hFFFF);
            else if (k == 65540) eall(9'h020, 9'h020, 16'hFFFF, 1'b0);
            tick();
        end
        clrErr = 1'b1; eall(9'h020, 9'h020, 16'd1, 1'b0); tick(); clrErr = 1'b0;
        idle(); eall(9'h000, 9'h020, 16'd1, 1'b0); tick();

        repeat (3) @(negedge hclk);
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
